alu_seq_ctrl: RTL and testbench

Sequencing front-end for the 32-bit ripple ALU built from `alu_top` slices. It accepts operation requests over a valid/ready handshake and decodes the 4-bit ALU control code into per-slice controls (`A_invert`, `B_invert`, `cin`, `operation`, `comp`). It drives the combinational ALU from registered operands, captures result and flags, and returns them over a second valid/ready handshake. It also runs an iterative 32-cycle unsigned multiply by reusing the ALU adder.

---
 rtl/alu_seq_ctrl_pkg.sv | 38 +++
 rtl/alu_ctrl_decode.sv | 46 ++++
 rtl/alu_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the ALU sequencing front-end: control codes,
// compare selects, FSM states and the decoded-control bundle.
package alu_seq_ctrl_pkg;

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_NOR  = 4'b1100;
  localparam logic [3:0] CTRL_NAND = 4'b1101;
  localparam logic [3:0] CTRL_CMP  = 4'b0111;
  localparam logic [3:0] CTRL_MUL  = 4'b1000;

  localparam logic [2:0] CMP_LT = 3'b000;
  localparam logic [2:0] CMP_GT = 3'b001;
  localparam logic [2:0] CMP_LE = 3'b010;
  localparam logic [2:0] CMP_GE = 3'b011;
  localparam logic [2:0] CMP_EQ = 3'b100;
  localparam logic [2:0] CMP_NE = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic       a_invert;
    logic       b_invert;
    logic       cin;
    logic [1:0] operation;
    logic [2:0] comp;
    logic       is_mul;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of the 4-bit ALU control code into per-slice controls.
module alu_ctrl_decode
  import alu_seq_ctrl_pkg::*;
(
  input  logic [3:0] in_ctrl,
  input  logic [2:0] in_cmp,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    case (in_ctrl)
      CTRL_AND:  dec.operation = 2'b00;
      CTRL_OR:   dec.operation = 2'b01;
      CTRL_ADD:  dec.operation = 2'b10;
      CTRL_SUB: begin
        dec.b_invert  = 1'b1;
        dec.cin       = 1'b1;
        dec.operation = 2'b10;
      end
      CTRL_NOR: begin
        dec.a_invert  = 1'b1;
        dec.b_invert  = 1'b1;
        dec.operation = 2'b00;
      end
      CTRL_NAND: begin
        dec.a_invert  = 1'b1;
        dec.b_invert  = 1'b1;
        dec.operation = 2'b01;
      end
      CTRL_CMP: begin
        dec.b_invert  = 1'b1;
        dec.cin       = 1'b1;
        dec.operation = 2'b11;
        dec.comp      = in_cmp;
      end
      // Multiply reuses the plain adder path every iteration.
      CTRL_MUL: begin
        dec.operation = 2'b10;
        dec.is_mul    = 1'b1;
      end
      default:   dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Request/response sequencer around an external combinational ALU, with an
// iterative shift-and-add unsigned multiply that reuses the ALU adder.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_ctrl,
  input  logic [2:0]       in_cmp,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_err,
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  output logic             alu_A_invert,
  output logic             alu_B_invert,
  output logic             alu_cin,
  output logic [1:0]       alu_operation,
  output logic [2:0]       alu_comp,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_cout,
  input  logic             alu_overflow
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  dec_t             dec;
  state_t           state_reg;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [WIDTH-1:0] mcand_next;
  logic [WIDTH-1:0] mplier_next;

  alu_ctrl_decode u_decode (
    .in_ctrl (in_ctrl),
    .in_cmp  (in_cmp),
    .dec     (dec)
  );

  assign mcand_next  = mcand_reg << 1;
  assign mplier_next = mplier_reg >> 1;

  // During MUL, alu_src1 is the product accumulator itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_zero      <= 1'b0;
      out_cout      <= 1'b0;
      out_ovf       <= 1'b0;
      out_err       <= 1'b0;
      alu_src1      <= '0;
      alu_src2      <= '0;
      alu_A_invert  <= 1'b0;
      alu_B_invert  <= 1'b0;
      alu_cin       <= 1'b0;
      alu_operation <= 2'b00;
      alu_comp      <= 3'b000;
      count_reg     <= '0;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (dec.illegal) begin
              out_result <= '0;
              out_zero   <= 1'b0;
              out_cout   <= 1'b0;
              out_ovf    <= 1'b0;
              out_err    <= 1'b1;
              out_valid  <= 1'b1;
              state_reg  <= ST_DONE;
            end else begin
              alu_A_invert  <= dec.a_invert;
              alu_B_invert  <= dec.b_invert;
              alu_cin       <= dec.cin;
              alu_operation <= dec.operation;
              alu_comp      <= dec.comp;
              if (dec.is_mul) begin
                alu_src1   <= '0;
                alu_src2   <= in_b[0] ? in_a : '0;
                mcand_reg  <= in_a;
                mplier_reg <= in_b;
                count_reg  <= '0;
                state_reg  <= ST_MUL;
              end else begin
                alu_src1  <= in_a;
                alu_src2  <= in_b;
                state_reg <= ST_EXEC;
              end
            end
          end
        end
        ST_EXEC: begin
          out_result <= alu_result;
          out_zero   <= alu_zero;
          out_cout   <= alu_cout;
          out_ovf    <= alu_overflow;
          out_err    <= 1'b0;
          out_valid  <= 1'b1;
          state_reg  <= ST_DONE;
        end
        ST_MUL: begin
          mcand_reg  <= mcand_next;
          mplier_reg <= mplier_next;
          count_reg  <= count_reg + 1'b1;
          if (count_reg == CNT_LAST) begin
            out_result <= alu_result;
            out_zero   <= (alu_result == '0);
            out_cout   <= 1'b0;
            out_ovf    <= 1'b0;
            out_err    <= 1'b0;
            out_valid  <= 1'b1;
            state_reg  <= ST_DONE;
          end else begin
            alu_src1 <= alu_result;
            alu_src2 <= mplier_next[0] ? mcand_next : '0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural 32-bit ALU on the alu_* side, an
// operation-level reference model with per-cycle compare, and directed vectors.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  in_ctrl;
  logic [2:0]  in_cmp;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_zero, out_cout, out_ovf, out_err;
  logic [31:0] alu_src1, alu_src2;
  logic        alu_A_invert, alu_B_invert, alu_cin;
  logic [1:0]  alu_operation;
  logic [2:0]  alu_comp;
  logic [31:0] alu_result;
  logic        alu_zero, alu_cout, alu_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_cmp(in_cmp),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_cout(out_cout), .out_ovf(out_ovf), .out_err(out_err),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_A_invert(alu_A_invert),
    .alu_B_invert(alu_B_invert), .alu_cin(alu_cin), .alu_operation(alu_operation),
    .alu_comp(alu_comp), .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_cout(alu_cout), .alu_overflow(alu_overflow)
  );

  // Behavioural ripple ALU built from the slice controls.
  logic [31:0] am, bm;
  logic [32:0] sum;
  logic        cmp_bit;
  always_comb begin
    am = alu_A_invert ? ~alu_src1 : alu_src1;
    bm = alu_B_invert ? ~alu_src2 : alu_src2;
    sum = {1'b0, am} + {1'b0, bm} + {32'b0, alu_cin};
    case (alu_comp)
      3'b000:  cmp_bit = $signed(alu_src1) <  $signed(alu_src2);
      3'b001:  cmp_bit = $signed(alu_src1) >  $signed(alu_src2);
      3'b010:  cmp_bit = $signed(alu_src1) <= $signed(alu_src2);
      3'b011:  cmp_bit = $signed(alu_src1) >= $signed(alu_src2);
      3'b100:  cmp_bit = alu_src1 == alu_src2;
      3'b101:  cmp_bit = alu_src1 != alu_src2;
      default: cmp_bit = 1'b0;
    endcase
    alu_result   = '0;
    alu_cout     = 1'b0;
    alu_overflow = 1'b0;
    case (alu_operation)
      2'b00: alu_result = am & bm;
      2'b01: alu_result = am | bm;
      2'b10: begin
        alu_result   = sum[31:0];
        alu_cout     = sum[32];
        alu_overflow = (am[31] == bm[31]) && (sum[31] != am[31]);
      end
      default: begin
        alu_result   = {31'b0, cmp_bit};
        alu_cout     = sum[32];
        alu_overflow = (am[31] == bm[31]) && (sum[31] != am[31]);
      end
    endcase
    alu_zero = (alu_result == 32'b0);
  end

  typedef struct packed {
    logic [31:0] result;
    logic        zero, cout, ovf, err;
  } rsp_t;

  // Operation-level reference: what the response must be for a request.
  function automatic rsp_t ref_op(input logic [3:0] c, input logic [2:0] k,
                                  input logic [31:0] a, input logic [31:0] b);
    rsp_t r;
    logic [32:0] s;
    logic [31:0] d;
    r = '0;
    d = a - b;
    case (c)
      4'b0000: r.result = a & b;
      4'b0001: r.result = a | b;
      4'b0010: begin
        s = {1'b0, a} + {1'b0, b};
        r.result = s[31:0];
        r.cout = s[32];
        r.ovf = (a[31] == b[31]) && (s[31] != a[31]);
      end
      4'b0110, 4'b0111: begin
        r.cout = (a >= b);
        r.ovf = (a[31] != b[31]) && (d[31] != a[31]);
        if (c == 4'b0110) r.result = d;
        else begin
          case (k)
            3'b000: r.result = 32'($signed(a) <  $signed(b));
            3'b001: r.result = 32'($signed(a) >  $signed(b));
            3'b010: r.result = 32'($signed(a) <= $signed(b));
            3'b011: r.result = 32'($signed(a) >= $signed(b));
            3'b100: r.result = 32'(a == b);
            3'b101: r.result = 32'(a != b);
            default: r.result = 32'b0;
          endcase
        end
      end
      4'b1100: r.result = ~(a | b);
      4'b1101: r.result = ~(a & b);
      4'b1000: r.result = a * b;
      default: r.err = 1'b1;
    endcase
    r.zero = !r.err && (r.result == 32'b0);
    return r;
  endfunction

  function automatic int lat_of(input logic [3:0] c);
    rsp_t r;
    r = ref_op(c, 3'b000, 32'b0, 32'b0);
    if (r.err) return 0;
    if (c == 4'b1000) return 32;
    return 1;
  endfunction

  // Expected {A_invert, B_invert, cin, operation, comp} for single-cycle ops.
  function automatic logic [31:0] exp_dec(input logic [3:0] c, input logic [2:0] k);
    case (c)
      4'b0000: return 32'b000_00_000;
      4'b0001: return 32'b000_01_000;
      4'b0010: return 32'b000_10_000;
      4'b0110: return 32'b011_10_000;
      4'b1100: return 32'b110_00_000;
      4'b1101: return 32'b110_01_000;
      4'b0111: return {24'b0, 5'b011_11, k};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Cycle-level model of the handshake timing.
  bit          m_live = 0, m_busy = 0, m_valid = 0, m_decchk = 0, m_rst = 0;
  int          m_cnt = 0;
  rsp_t        m_exp = '0;
  logic [3:0]  m_ctrl = '0;
  logic [2:0]  m_cmp = '0;
  logic [31:0] m_a = '0, m_b = '0;

  always @(posedge clk) begin
    m_live   <= 1;
    m_decchk <= 0;
    m_rst    <= 0;
    if (rst) begin
      m_busy  <= 0;
      m_valid <= 0;
      m_rst   <= 1;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_exp    <= ref_op(in_ctrl, in_cmp, in_a, in_b);
        m_ctrl   <= in_ctrl;
        m_cmp    <= in_cmp;
        m_a      <= in_a;
        m_b      <= in_b;
        m_busy   <= 1;
        m_cnt    <= lat_of(in_ctrl);
        m_valid  <= (lat_of(in_ctrl) == 0);
        m_decchk <= (lat_of(in_ctrl) == 1);
      end
    end else if (!m_valid) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_valid <= 1;
    end else if (out_ready) begin
      m_busy  <= 0;
      m_valid <= 0;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("in_ready", 32'(in_ready), 32'(!m_busy));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("out_result", out_result, m_exp.result);
        chk("out_flags", {28'b0, out_zero, out_cout, out_ovf, out_err},
            {28'b0, m_exp.zero, m_exp.cout, m_exp.ovf, m_exp.err});
      end
      if (m_decchk) begin
        chk("alu_ctrl", {24'b0, alu_A_invert, alu_B_invert, alu_cin, alu_operation, alu_comp},
            exp_dec(m_ctrl, m_cmp));
        chk("alu_src1", alu_src1, m_a);
        chk("alu_src2", alu_src2, m_b);
      end
      if (m_rst) begin
        chk("rst_out", out_result | {27'b0, out_zero, out_cout, out_ovf, out_err, out_valid}, 32'b0);
        chk("rst_alu", alu_src1 | alu_src2 |
            {24'b0, alu_A_invert, alu_B_invert, alu_cin, alu_operation, alu_comp}, 32'b0);
      end
    end
  end

  logic [31:0] r_res;
  logic        r_zero, r_cout, r_ovf, r_err;

  task automatic run_op(input string nm, input logic [3:0] c, input logic [2:0] k,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat);
    int n;
    @(negedge clk);
    in_ctrl = c; in_cmp = k; in_a = a; in_b = b; in_valid = 1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: in_ready stuck at 0, required 1", nm);
      in_valid = 0;
      return;
    end
    @(negedge clk);
    in_valid = 0;
    n = 1;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'(exp_lat));
    chk({nm, "_result"}, out_result, exp_res);
    r_res = out_result; r_zero = out_zero; r_cout = out_cout; r_ovf = out_ovf; r_err = out_err;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  logic [3:0]  t_ctrl [8] = '{4'b0000, 4'b0001, 4'b1101, 4'b0111, 4'b0111, 4'b0111, 4'b0110, 4'b0111};
  logic [2:0]  t_cmp  [8] = '{3'b000, 3'b000, 3'b000, 3'b011, 3'b100, 3'b101, 3'b000, 3'b001};
  logic [31:0] t_a    [8] = '{32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'hFFFFFFFB,
                              32'd7, 32'd7, 32'd3, 32'd1};
  logic [31:0] t_b    [8] = '{32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0F0F0F0F, 32'd3,
                              32'd7, 32'd7, 32'd5, 32'hFFFFFFFF};
  logic [31:0] t_exp  [8] = '{32'h0F000F00, 32'hFF0FFF0F, 32'hF0FFF0FF, 32'd0,
                              32'd1, 32'd0, 32'hFFFFFFFE, 32'd1};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1; in_valid = 0; in_ctrl = '0; in_cmp = '0; in_a = '0; in_b = '0; out_ready = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);

    run_op("add_ovf", 4'b0010, 3'b000, 32'h7FFFFFFF, 32'd1, 32'h80000000, 2);
    chk("add_ovf_flag", {30'b0, r_ovf, r_cout}, 32'b10);
    run_op("sub_zero", 4'b0110, 3'b000, 32'd5, 32'd5, 32'd0, 2);
    chk("sub_zero_flags", {30'b0, r_zero, r_cout}, 32'b11);
    run_op("cmp_lt", 4'b0111, 3'b000, 32'hFFFFFFFF, 32'd1, 32'd1, 2);
    run_op("mul_a", 4'b1000, 3'b000, 32'h00012345, 32'h00000100, 32'h01234500, 33);
    run_op("mul_ff", 4'b1000, 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
    run_op("illegal", 4'b1111, 3'b000, 32'h1234, 32'h5678, 32'd0, 1);
    chk("illegal_err", {31'b0, r_err}, 32'd1);
    run_op("nor", 4'b1100, 3'b000, 32'd0, 32'd0, 32'hFFFFFFFF, 2);
    for (int i = 0; i < 8; i++)
      run_op($sformatf("tbl%0d", i), t_ctrl[i], t_cmp[i], t_a[i], t_b[i], t_exp[i], 2);

    // Backpressure with a second request pending.
    @(negedge clk);
    in_ctrl = 4'b0010; in_cmp = 3'b000; in_a = 32'd10; in_b = 32'd20; in_valid = 1;
    @(negedge clk);
    in_ctrl = 4'b0110; in_a = 32'd9; in_b = 32'd4;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_result", out_result, 32'd30);
      @(negedge clk);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("bp_ready_after_hs", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 0;
    chk("bp_next_accepted", 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_sub_result", out_result, 32'd5);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;

    // Reset in the middle of a multiply.
    @(negedge clk);
    in_ctrl = 4'b1000; in_a = 32'd3; in_b = 32'd7; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (10) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midmul_in_ready", 32'(in_ready), 32'd1);
    chk("midmul_out_valid", 32'(out_valid), 32'd0);
    chk("midmul_out_result", out_result, 32'd0);
    run_op("add_after_rst", 4'b0010, 3'b000, 32'd2, 32'd3, 32'd5, 2);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
